// File: rtl/branch_predict_ctrl.sv
// Branch history table of 2-bit counters with a shared access slot.
// IF lookups and buffered EX updates are arbitrated one per cycle.
module branch_predict_ctrl #(
  parameter int IDX_W      = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int PC_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tbl_clear,
  input  logic            pred_req,
  input  logic [PC_W-1:0] pred_pc,
  output logic            pred_ready,
  output logic            pred_valid,
  output logic            pred_taken,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  output logic            upd_ready,
  output logic            init_busy
);

  localparam int N  = 1 << IDX_W;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] init_idx;
  logic [1:0]       bht [N];
  logic [IDX_W-1:0] q_idx [FIFO_DEPTH];
  logic             q_tk [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             run;
  logic             open;
  logic             full;
  logic             lookup;
  logic             push;
  logic             drain;
  logic [IDX_W-1:0] p_idx;
  logic [IDX_W-1:0] u_idx;
  logic [IDX_W-1:0] h_idx;
  logic             h_tk;
  logic [1:0]       h_cnt;
  logic [1:0]       h_next;
  logic             unused_pc;

  assign run    = (state == RUN);
  assign open   = run && !tbl_clear;
  assign full   = (count == FULL_CNT);
  assign p_idx  = pred_pc[IDX_W+1:2];
  assign u_idx  = upd_pc[IDX_W+1:2];
  assign h_idx  = q_idx[rd_ptr];
  assign h_tk   = q_tk[rd_ptr];
  assign h_cnt  = bht[h_idx];

  assign pred_ready = open && !full;
  assign upd_ready  = open && !full;
  assign init_busy  = (state == INIT);

  assign lookup = pred_req && pred_ready;
  assign push   = upd_valid && upd_ready;
  // A full FIFO steals the slot so EX can never be blocked forever.
  assign drain  = open && (count != '0)
               && (full || !pred_req);

  always_comb begin
    h_next = h_cnt;
    if (h_tk) begin
      if (h_cnt != 2'b11) h_next = h_cnt + 2'd1;
    end else begin
      if (h_cnt != 2'b00) h_next = h_cnt - 2'd1;
    end
  end

  assign unused_pc = ^{pred_pc[PC_W-1:IDX_W+2],
                       pred_pc[1:0],
                       upd_pc[PC_W-1:IDX_W+2],
                       upd_pc[1:0]};

  always_ff @(posedge clk) begin
    if (!tbl_clear && state == INIT)
      bht[init_idx] <= 2'b10;
    else if (drain)
      bht[h_idx] <= h_next;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr] <= u_idx;
      q_tk[wr_ptr]  <= upd_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      init_idx   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      pred_valid <= lookup;
      if (lookup)
        pred_taken <= bht[p_idx][1];
      if (tbl_clear) begin
        state    <= INIT;
        init_idx <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        unique case (state)
          INIT: begin
            init_idx <= init_idx + IDX_W'(1);
            if (&init_idx) state <= RUN;
          end
          RUN: begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (drain) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(drain);
          end
          default: state <= INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed and random checks of branch_predict_ctrl against a
// queue-based model of the table and update buffer.
module tb_branch_predict_ctrl;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tbl_clear = 1'b0;
  logic        pred_req = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        upd_ready;
  logic        init_busy;

  int checks = 0;
  int errors = 0;

  int mtbl [N];
  int qi [$];
  bit qt [$];
  bit m_run;
  int m_iidx;
  bit exp_valid;
  bit exp_taken;

  branch_predict_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tbl_clear  (tbl_clear),
    .pred_req   (pred_req),
    .pred_pc    (pred_pc),
    .pred_ready (pred_ready),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_ready  (upd_ready),
    .init_busy  (init_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ix(logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic void mreset();
    m_run = 1'b0;
    m_iidx = 0;
    qi.delete();
    qt.delete();
    exp_valid = 1'b0;
  endfunction

  task automatic step(input bit clr, input bit rq, input logic [31:0] ppc,
                      input bit uv, input logic [31:0] upc, input bit ut);
    bit full, opn, lk, dr, ps, t;
    int i;
    @(negedge clk);
    tbl_clear = clr;
    pred_req  = rq;
    pred_pc   = ppc;
    upd_valid = uv;
    upd_pc    = upc;
    upd_taken = ut;
    opn  = m_run && !clr;
    full = (qi.size() == 4);
    #1;
    chk("pred_ready", pred_ready, opn && !full);
    chk("upd_ready", upd_ready, opn && !full);
    @(posedge clk);
    if (clr) begin
      m_run = 1'b0;
      m_iidx = 0;
      qi.delete();
      qt.delete();
      exp_valid = 1'b0;
    end else if (!m_run) begin
      mtbl[m_iidx] = 2;
      m_iidx++;
      if (m_iidx == N) m_run = 1'b1;
      exp_valid = 1'b0;
    end else begin
      lk = rq && !full;
      dr = (qi.size() > 0) && (full || !rq);
      ps = uv && !full;
      exp_valid = lk;
      if (lk) exp_taken = (mtbl[ix(ppc)] >= 2);
      if (dr) begin
        i = qi.pop_front();
        t = qt.pop_front();
        if (t) mtbl[i] = (mtbl[i] == 3) ? 3 : mtbl[i] + 1;
        else   mtbl[i] = (mtbl[i] == 0) ? 0 : mtbl[i] - 1;
      end
      if (ps) begin
        qi.push_back(ix(upc));
        qt.push_back(ut);
      end
    end
    #1;
    chk("pred_valid", pred_valid, exp_valid);
    if (exp_valid) chk("pred_taken", pred_taken, exp_taken);
    chk("init_busy", init_busy, !m_run);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic look(string tag, logic [31:0] pc, bit exp);
    step(0, 1, pc, 0, 0, 0);
    chk(tag, pred_taken, exp);
  endtask

  task automatic push(logic [31:0] pc, bit t);
    step(0, 0, 0, 1, pc, t);
  endtask

  initial begin
    mreset();
    #14;
    chk("rst_busy", init_busy, 1);
    chk("rst_pred_ready", pred_ready, 0);
    chk("rst_upd_ready", upd_ready, 0);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_taken", pred_taken, 0);
    #2 rst_n = 1'b1;

    // init sweep then default weakly-taken prediction
    idle(63);
    chk("t1_busy_last", init_busy, 1);
    idle(1);
    chk("t1_busy_done", init_busy, 0);
    look("t1_wt", 32'h0000_1234, 1);

    // counter walk on 0x40
    push(32'h40, 0);
    push(32'h40, 0);
    idle(2);
    look("t2_snt", 32'h40, 0);
    push(32'h40, 1);
    idle(2);
    look("t2_wnt", 32'h40, 0);
    push(32'h40, 1);
    idle(2);
    look("t2_wt", 32'h40, 1);

    // saturation on 0x80
    push(32'h80, 1);
    push(32'h80, 1);
    push(32'h80, 1);
    idle(3);
    look("t4_st", 32'h80, 1);
    push(32'h80, 0);
    idle(2);
    look("t4_wt", 32'h80, 1);

    // lookups hold the slot until the FIFO fills
    for (int k = 0; k < 4; k++) step(0, 1, 32'h100, 1, 32'h204, 0);
    chk("t3_full_upd", upd_ready, 0);
    chk("t3_full_pred", pred_ready, 0);
    step(0, 1, 32'h100, 0, 0, 0);
    chk("t3_drain_novalid", pred_valid, 0);
    chk("t3_upd_again", upd_ready, 1);

    // clear discards the 3 queued not-taken updates
    step(1, 1, 32'h100, 1, 32'h204, 0);
    chk("t5_busy", init_busy, 1);
    idle(64);
    chk("t5_busy_done", init_busy, 0);
    look("t5_wt_204", 32'h204, 1);
    look("t5_wt_40", 32'h40, 1);
    look("t5_wt_80", 32'h80, 1);

    // async reset in the middle of init
    step(1, 0, 0, 0, 0, 0);
    idle(20);
    rst_n = 1'b0;
    #1;
    mreset();
    chk("t6_busy", init_busy, 1);
    chk("t6_pred_ready", pred_ready, 0);
    chk("t6_upd_ready", upd_ready, 0);
    chk("t6_pred_valid", pred_valid, 0);
    chk("t6_pred_taken", pred_taken, 0);
    #1 rst_n = 1'b1;
    idle(63);
    chk("t6_busy_last", init_busy, 1);
    idle(1);
    chk("t6_busy_done", init_busy, 0);

    // random traffic over a few colliding indices
    for (int k = 0; k < 800; k++) begin
      step($urandom_range(0, 149) == 0,
           $urandom_range(0, 2) != 0,
           32'($urandom_range(0, 3)) << 2,
           $urandom_range(0, 1) == 1,
           32'($urandom_range(0, 3)) << 2,
           $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
